pc_unit_ras: RTL and testbench

//  Parametrised program-counter unit for the multicycle MIPS datapath; next generation of the PC register.

---
 rtl/pc_unit_ras.sv | 146 ++++++++++++++
 tb/tb_pc_unit_ras.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit_ras.sv
// Program-counter unit for the multicycle MIPS datapath: next-PC select, branch gating,
// exception redirect with EPC capture and a circular return-address stack for JAL/JR.
module pc_unit_ras #(
   parameter int unsigned      WIDTH        = 32,
   parameter int unsigned      RAS_DEPTH    = 4,
   parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h00000000,
   parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h80000180,
   parameter int unsigned      INC          = 4,
   parameter int unsigned      ALIGN_BITS   = 2
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             pc_write,
   input  logic             pc_write_cond,
   input  logic             alu_zero,
   input  logic [1:0]       pc_src,
   input  logic [WIDTH-1:0] seq_addr,
   input  logic [WIDTH-1:0] branch_addr,
   input  logic [WIDTH-1:0] jump_addr,
   input  logic             ras_push,
   input  logic             exc_req,
   output logic [WIDTH-1:0] pc_out,
   output logic [WIDTH-1:0] epc_out,
   output logic             ras_empty,
   output logic             ras_full,
   output logic             align_err,
   output logic             ras_underflow
);

   localparam int unsigned      PTR_W      = $clog2(RAS_DEPTH);
   localparam int unsigned      CNT_W      = $clog2(RAS_DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(RAS_DEPTH);
   localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);
   localparam logic [WIDTH-1:0] LINK_INC   = WIDTH'(INC);

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] epc_q, epc_d;
   logic [PTR_W-1:0] top_q, top_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             align_err_q, align_err_d;
   logic             ras_underflow_q, ras_underflow_d;

   logic [WIDTH-1:0] ras_q [RAS_DEPTH];
   logic             mem_we;
   logic [PTR_W-1:0] mem_waddr;
   logic [WIDTH-1:0] mem_wdata;

   logic             we;
   logic             is_pop;
   logic             underflow_hit;
   logic [WIDTH-1:0] link;
   logic [WIDTH-1:0] target;

   function automatic logic misaligned(input logic [WIDTH-1:0] addr);
      return (addr & ALIGN_MASK) != '0;
   endfunction

   assign we            = pc_write | (pc_write_cond & alu_zero);
   assign is_pop        = (pc_src == 2'b11);
   assign underflow_hit = is_pop && (cnt_q == '0);
   assign link          = pc_q + LINK_INC;

   always_comb begin
      target = seq_addr;
      unique case (pc_src)
         2'b00:   target = seq_addr;
         2'b01:   target = branch_addr;
         2'b10:   target = jump_addr;
         default: target = ras_q[top_q];
      endcase
   end

   // top_q indexes the most recent push; a push advances it, so the oldest slot is reused when full
   always_comb begin
      pc_d            = pc_q;
      epc_d           = epc_q;
      top_d           = top_q;
      cnt_d           = cnt_q;
      align_err_d     = 1'b0;
      ras_underflow_d = 1'b0;
      mem_we          = 1'b0;
      mem_waddr       = top_q;
      mem_wdata       = link;
      if (exc_req) begin
         pc_d  = EXC_VECTOR;
         epc_d = pc_q;
      end else if (we) begin
         if (underflow_hit) begin
            ras_underflow_d = 1'b1;
         end else if (misaligned(target)) begin
            align_err_d = 1'b1;
         end else begin
            pc_d = target;
            if (is_pop && ras_push) begin
               mem_we = 1'b1;
            end else if (is_pop) begin
               top_d = top_q - PTR_ONE;
               cnt_d = cnt_q - CNT_ONE;
            end else if (ras_push) begin
               top_d     = top_q + PTR_ONE;
               mem_we    = 1'b1;
               mem_waddr = top_q + PTR_ONE;
               if (cnt_q != FULL_CNT) begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end
      end
   end

   // Datapath convention: all state moves on the falling edge
   always_ff @(negedge clock) begin
      if (!reset_n) begin
         pc_q            <= RESET_VECTOR;
         epc_q           <= '0;
         top_q           <= '0;
         cnt_q           <= '0;
         align_err_q     <= 1'b0;
         ras_underflow_q <= 1'b0;
      end else begin
         pc_q            <= pc_d;
         epc_q           <= epc_d;
         top_q           <= top_d;
         cnt_q           <= cnt_d;
         align_err_q     <= align_err_d;
         ras_underflow_q <= ras_underflow_d;
      end
   end

   // Stack contents need no reset; an entry is only read while the count covers it
   always_ff @(negedge clock) begin
      if (mem_we) begin
         ras_q[mem_waddr] <= mem_wdata;
      end
   end

   assign pc_out        = pc_q;
   assign epc_out       = epc_q;
   assign ras_empty     = (cnt_q == '0);
   assign ras_full      = (cnt_q == FULL_CNT);
   assign align_err     = align_err_q;
   assign ras_underflow = ras_underflow_q;

endmodule

// File: tb/tb_pc_unit_ras.sv
// Scoreboard bench for pc_unit_ras: a queue-based reference model predicts each edge,
// expectations are queued at drive time and popped once the falling edge has updated the DUT.
module tb_pc_unit_ras;

   localparam logic [31:0] EXC_VEC = 32'h80000180;
   localparam int          DEPTH   = 4;

   logic        clock;
   logic        reset_n;
   logic        pc_write;
   logic        pc_write_cond;
   logic        alu_zero;
   logic [1:0]  pc_src;
   logic [31:0] seq_addr;
   logic [31:0] branch_addr;
   logic [31:0] jump_addr;
   logic        ras_push;
   logic        exc_req;
   logic [31:0] pc_out;
   logic [31:0] epc_out;
   logic        ras_empty;
   logic        ras_full;
   logic        align_err;
   logic        ras_underflow;

   pc_unit_ras dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .alu_zero      (alu_zero),
      .pc_src        (pc_src),
      .seq_addr      (seq_addr),
      .branch_addr   (branch_addr),
      .jump_addr     (jump_addr),
      .ras_push      (ras_push),
      .exc_req       (exc_req),
      .pc_out        (pc_out),
      .epc_out       (epc_out),
      .ras_empty     (ras_empty),
      .ras_full      (ras_full),
      .align_err     (align_err),
      .ras_underflow (ras_underflow)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] epc;
      logic        empty;
      logic        full;
      logic        aerr;
      logic        uflow;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] m_ras[$];
   logic [31:0] m_pc;
   logic [31:0] m_epc;
   logic        m_aerr;
   logic        m_uf;
   int          total;
   int          bad;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model(input logic rn, input logic pw, input logic pwc, input logic az,
                        input logic [1:0] src, input logic [31:0] sa, input logic [31:0] ba,
                        input logic [31:0] ja, input logic push, input logic exc);
      logic [31:0] tgt;
      logic [31:0] lnk;
      logic        pop;
      exp_t        e;
      m_aerr = 1'b0;
      m_uf   = 1'b0;
      pop    = (src == 2'b11);
      lnk    = m_pc + 32'd4;
      case (src)
         2'b00:   tgt = sa;
         2'b01:   tgt = ba;
         2'b10:   tgt = ja;
         default: tgt = (m_ras.size() > 0) ? m_ras[$] : 32'h0;
      endcase
      if (!rn) begin
         m_pc  = 32'h0;
         m_epc = 32'h0;
         m_ras.delete();
      end else if (exc) begin
         m_epc = m_pc;
         m_pc  = EXC_VEC;
      end else if (pw || (pwc && az)) begin
         if (pop && m_ras.size() == 0) begin
            m_uf = 1'b1;
         end else if (tgt[1:0] != 2'b00) begin
            m_aerr = 1'b1;
         end else begin
            if (pop && push) begin
               m_ras[m_ras.size()-1] = lnk;
            end else if (pop) begin
               void'(m_ras.pop_back());
            end else if (push) begin
               m_ras.push_back(lnk);
               if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end
            m_pc = tgt;
         end
      end
      e.pc    = m_pc;
      e.epc   = m_epc;
      e.empty = (m_ras.size() == 0);
      e.full  = (m_ras.size() == DEPTH);
      e.aerr  = m_aerr;
      e.uflow = m_uf;
      sb.push_back(e);
   endtask

   task automatic cyc(input logic rn, input logic pw, input logic pwc, input logic az,
                      input logic [1:0] src, input logic [31:0] sa, input logic [31:0] ba,
                      input logic [31:0] ja, input logic push, input logic exc);
      exp_t e;
      @(posedge clock);
      reset_n       = rn;
      pc_write      = pw;
      pc_write_cond = pwc;
      alu_zero      = az;
      pc_src        = src;
      seq_addr      = sa;
      branch_addr   = ba;
      jump_addr     = ja;
      ras_push      = push;
      exc_req       = exc;
      model(rn, pw, pwc, az, src, sa, ba, ja, push, exc);
      @(negedge clock);
      #1;
      if (sb.size() == 0) begin
         check("sb_empty", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check("pc_out", pc_out, e.pc);
         check("epc_out", epc_out, e.epc);
         check("ras_empty", {31'd0, ras_empty}, {31'd0, e.empty});
         check("ras_full", {31'd0, ras_full}, {31'd0, e.full});
         check("align_err", {31'd0, align_err}, {31'd0, e.aerr});
         check("ras_underflow", {31'd0, ras_underflow}, {31'd0, e.uflow});
      end
   endtask

   task automatic wr(input logic [1:0] src, input logic [31:0] a, input logic push);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, src, a, a, a, push, 1'b0);
   endtask

   task automatic idle();
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [31:0] ra;
      total = 0;
      bad   = 0;
      m_pc  = 32'h0;
      m_epc = 32'h0;
      m_aerr = 1'b0;
      m_uf  = 1'b0;
      reset_n = 1'b0; pc_write = 1'b0; pc_write_cond = 1'b0; alu_zero = 1'b0;
      pc_src = 2'b00; seq_addr = '0; branch_addr = '0; jump_addr = '0;
      ras_push = 1'b0; exc_req = 1'b0;

      // reset, then sequential write
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h8, 32'h0, 32'h0, 1'b1, 1'b0);
      check("reset_pc_const", pc_out, 32'h0);
      wr(2'b00, 32'h4, 1'b0);
      check("seq_pc_const", pc_out, 32'h4);

      // conditional branch
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 32'h0, 32'h40, 32'h0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 32'h0, 32'h40, 32'h0, 1'b0, 1'b0);
      check("branch_taken_const", pc_out, 32'h40);

      // JAL / JR
      wr(2'b00, 32'h100, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 32'h0, 32'h0, 32'h200, 1'b1, 1'b0);
      wr(2'b11, 32'h0, 1'b0);
      check("jr_return_const", pc_out, 32'h104);

      // overfill the stack, drain LIFO, then underflow
      for (int i = 0; i < 5; i++) wr(2'b00, 32'h1000 + 32'(i) * 32'h10, 1'b1);
      for (int i = 0; i < 5; i++) wr(2'b11, 32'h0, 1'b0);
      idle();

      // simultaneous pop and push replaces the top
      wr(2'b00, 32'h500, 1'b1);
      wr(2'b00, 32'h600, 1'b1);
      wr(2'b11, 32'h0, 1'b1);
      wr(2'b11, 32'h0, 1'b0);
      wr(2'b11, 32'h0, 1'b0);

      // exception outranks a write and leaves the stack alone
      wr(2'b00, 32'h300, 1'b1);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
      check("exc_epc_const", epc_out, 32'h300);

      // misaligned target, then reset in the middle of a pop
      wr(2'b00, 32'h102, 1'b0);
      idle();
      wr(2'b00, 32'h800, 1'b1);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      wr(2'b11, 32'h0, 1'b0);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         ra = $urandom;
         if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
         cyc(($urandom_range(0, 60) != 0), ($urandom_range(0, 2) == 0), $urandom_range(0, 1),
             $urandom_range(0, 1), 2'($urandom_range(0, 3)), ra, {ra[31:2], 2'b00},
             {ra[15:0], ra[17:2], 2'b00}, $urandom_range(0, 1), ($urandom_range(0, 15) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
